// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus sequencer.
package rtc_pkg;

  localparam logic [3:0] SKIP_IDX = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP2 = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // RTC register address for each local index; index 6 (weekday) has no RTC address.
  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd7:    a = 8'h41;
      4'd8:    a = 8'h42;
      4'd9:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Next local index, stepping over the unused weekday slot.
  function automatic logic [3:0] next_idx(input logic [3:0] idx);
    logic [3:0] n;
    n = idx + 4'd1;
    if (n == SKIP_IDX) n = idx + 4'd2;
    return n;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter; tc is high while the count sits at zero.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);

  logic [7:0] count;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 8'd1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences write/read bursts over the RTC multiplexed address/data bus.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned T_PHASE = 4,
  parameter int unsigned N_REGS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rd_nwr,
  output logic       busy,
  output logic       done,
  output logic       reg_wr,
  output logic [3:0] addr_mem_local,
  input  logic [7:0] dato_para_rtc,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_a_d,
  output logic [7:0] rd_data,
  output logic [3:0] rd_addr,
  output logic       rd_valid
);

  localparam logic [7:0] PHASE_LOAD = 8'(T_PHASE - 1);
  localparam logic [3:0] LAST_IDX   = 4'(N_REGS - 1);

  state_t     state, state_d;
  logic       rd_mode, rd_mode_d;
  logic [7:0] data_latch, data_latch_d;
  logic       phase_tc;

  logic       busy_d, done_d, reg_wr_d, rd_valid_d;
  logic       cs_n_d, rd_n_d, wr_n_d, a_d_d, oe_d;
  logic [3:0] addr_d, rd_addr_d;
  logic [7:0] ad_out_d, rd_data_d;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_d != state),
    .load_val (PHASE_LOAD),
    .tc       (phase_tc)
  );

  // State register with burst mode and write-data latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_mode    <= 1'b0;
      data_latch <= '0;
    end else begin
      state      <= state_d;
      rd_mode    <= rd_mode_d;
      data_latch <= data_latch_d;
    end
  end

  // Next-state logic; FIN also accepts start so held-high start chains bursts.
  always_comb begin
    state_d      = state;
    rd_mode_d    = rd_mode;
    data_latch_d = data_latch;
    case (state)
      ST_IDLE: if (start) begin
        state_d   = ST_ADDR;
        rd_mode_d = rd_nwr;
      end
      ST_ADDR: if (phase_tc) state_d = ST_GAP1;
      ST_GAP1: begin
        state_d      = ST_DATA;
        data_latch_d = dato_para_rtc;
      end
      ST_DATA: if (phase_tc) state_d = ST_GAP2;
      ST_GAP2: state_d = (addr_mem_local == LAST_IDX) ? ST_FIN : ST_ADDR;
      ST_FIN: begin
        if (start) begin
          state_d   = ST_ADDR;
          rd_mode_d = rd_nwr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next register values derived from the state being entered,
  // so every output is registered yet aligned with its state.
  always_comb begin
    busy_d     = 1'b1;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    reg_wr_d   = rd_mode_d;
    addr_d     = addr_mem_local;
    cs_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    a_d_d      = 1'b1;
    oe_d       = 1'b0;
    ad_out_d   = rtc_ad_out;
    rd_data_d  = rd_data;
    rd_addr_d  = rd_addr;
    case (state_d)
      ST_IDLE: begin
        busy_d   = 1'b0;
        reg_wr_d = 1'b1;
        addr_d   = '0;
      end
      ST_ADDR: begin
        if (state == ST_GAP2)      addr_d = next_idx(addr_mem_local);
        else if (state != ST_ADDR) addr_d = '0;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        oe_d     = 1'b1;
        ad_out_d = rtc_addr(addr_d);
      end
      ST_DATA: begin
        cs_n_d = 1'b0;
        a_d_d  = 1'b0;
        if (rd_mode_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d   = 1'b0;
          oe_d     = 1'b1;
          ad_out_d = data_latch_d;
        end
      end
      ST_GAP2: begin
        if (rd_mode_d && state == ST_DATA) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rtc_ad_in;
          rd_addr_d  = addr_mem_local;
        end
      end
      ST_FIN: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        reg_wr_d = 1'b1;
        addr_d   = '0;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_valid       <= 1'b0;
      reg_wr         <= 1'b1;
      addr_mem_local <= '0;
      rtc_cs_n       <= 1'b1;
      rtc_rd_n       <= 1'b1;
      rtc_wr_n       <= 1'b1;
      rtc_a_d        <= 1'b1;
      rtc_ad_oe      <= 1'b0;
      rtc_ad_out     <= '0;
      rd_data        <= '0;
      rd_addr        <= '0;
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      rd_valid       <= rd_valid_d;
      reg_wr         <= reg_wr_d;
      addr_mem_local <= addr_d;
      rtc_cs_n       <= cs_n_d;
      rtc_rd_n       <= rd_n_d;
      rtc_wr_n       <= wr_n_d;
      rtc_a_d        <= a_d_d;
      rtc_ad_oe      <= oe_d;
      rtc_ad_out     <= ad_out_d;
      rd_data        <= rd_data_d;
      rd_addr        <= rd_addr_d;
    end
  end

endmodule
